// File: rtl/sequential_divider.sv
// Iterative restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per clock.
// Uses the same write/divide/display command protocol as the sequential multiplier.
module sequential_divider #(
    parameter int unsigned p_data_width = 4
) (
    input  logic                      i_w_clk,
    input  logic                      i_w_reset,
    input  logic [2*p_data_width-1:0] i_w_a,
    input  logic [p_data_width-1:0]   i_w_b,
    input  logic                      i_w_write,
    input  logic                      i_w_divide,
    input  logic                      i_w_display,
    output logic [2*p_data_width-1:0] o_w_disp_a,
    output logic [p_data_width-1:0]   o_w_disp_b,
    output logic [p_data_width-1:0]   o_w_quotient,
    output logic [p_data_width-1:0]   o_w_remainder,
    output logic                      o_w_busy,
    output logic                      o_w_done,
    output logic                      o_w_div_by_zero,
    output logic                      o_w_overflow
);

    localparam int unsigned N  = p_data_width;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone, StDisplay} state_e;

    state_e            state_q;
    logic [2*N-1:0]    a_q;
    logic [N-1:0]      b_q;
    logic [N-1:0]      quot_q;
    logic [N-1:0]      rem_q;
    logic [N-1:0]      r_q;
    logic [N-1:0]      q_q;
    logic [CW-1:0]     cnt_q;
    logic              dbz_q;
    logic              ovf_q;

    logic [N:0]        trial;
    logic [N:0]        diff;
    logic              qbit;
    logic [N-1:0]      r_step;
    logic [N-1:0]      q_step;

    // One restoring step: shift the next dividend bit into the partial remainder.
    always_comb begin
        trial  = {r_q, q_q[N-1]};
        diff   = trial - {1'b0, b_q};
        qbit   = (trial >= {1'b0, b_q});
        r_step = qbit ? diff[N-1:0] : trial[N-1:0];
        q_step = {q_q[N-2:0], qbit};
    end

    always_ff @(posedge i_w_clk) begin
        if (!i_w_reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    r_q   <= r_step;
                    q_q   <= q_step;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        quot_q  <= q_step;
                        rem_q   <= r_step;
                        state_q <= StDone;
                    end
                end
                default: begin
                    if (i_w_write) begin
                        a_q     <= i_w_a;
                        b_q     <= i_w_b;
                        quot_q  <= '0;
                        rem_q   <= '0;
                        dbz_q   <= 1'b0;
                        ovf_q   <= 1'b0;
                        state_q <= StIdle;
                    end else if (i_w_divide) begin
                        if (b_q == '0) begin
                            dbz_q   <= 1'b1;
                            ovf_q   <= 1'b0;
                            quot_q  <= '1;
                            rem_q   <= a_q[N-1:0];
                            state_q <= StDone;
                        end else if (a_q[2*N-1:N] >= b_q) begin
                            // Quotient would not fit in N bits.
                            ovf_q   <= 1'b1;
                            dbz_q   <= 1'b0;
                            quot_q  <= '1;
                            rem_q   <= '0;
                            state_q <= StDone;
                        end else begin
                            dbz_q   <= 1'b0;
                            ovf_q   <= 1'b0;
                            r_q     <= a_q[2*N-1:N];
                            q_q     <= a_q[N-1:0];
                            cnt_q   <= CW'(N);
                            state_q <= StRun;
                        end
                    end else if (i_w_display) begin
                        state_q <= StDisplay;
                    end else if (state_q == StDisplay) begin
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    assign o_w_disp_a      = a_q;
    assign o_w_disp_b      = b_q;
    assign o_w_quotient    = (state_q == StDisplay) ? quot_q : '0;
    assign o_w_remainder   = (state_q == StDisplay) ? rem_q : '0;
    assign o_w_busy        = (state_q == StRun);
    assign o_w_done        = (state_q == StDone);
    assign o_w_div_by_zero = dbz_q;
    assign o_w_overflow    = ovf_q;

endmodule
